multi_port_memory: RTL and testbench

- Byte-addressed data memory with one write port and a parametrised number of read ports, on a single clock.
- Supports word, half and byte access modes, with optional sign extension on reads.
- Clears its own contents after reset, then enters service.
- Detects misaligned accesses.
- Serves as the shared instruction/data store for the multi-cycle and pipelined datapaths, which need more than two read ports and registered reads.

---
 rtl/multi_port_memory_if.sv | 29 ++
 rtl/multi_port_memory.sv | 145 ++++++++++++++
 tb/tb_multi_port_memory.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_port_memory_if.sv
// Bus bundle for multi_port_memory: one write port, READ_PORTS packed read ports, status flags.
interface multi_port_memory_if #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned READ_PORTS    = 2
);
    logic                               write_in;
    logic [1:0]                         write_mode_in;
    logic [ADDRESS_WIDTH-1:0]           write_address_in;
    logic [31:0]                        write_data_in;
    logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_address_in;
    logic [READ_PORTS*2-1:0]            read_mode_in;
    logic [READ_PORTS-1:0]              read_signed_in;
    logic [READ_PORTS*32-1:0]           read_data_out;
    logic [READ_PORTS-1:0]              read_error_out;
    logic                               write_error_out;
    logic                               ready_out;

    modport master (
        output write_in, write_mode_in, write_address_in, write_data_in,
        output read_address_in, read_mode_in, read_signed_in,
        input  read_data_out, read_error_out, write_error_out, ready_out
    );

    modport slave (
        input  write_in, write_mode_in, write_address_in, write_data_in,
        input  read_address_in, read_mode_in, read_signed_in,
        output read_data_out, read_error_out, write_error_out, ready_out
    );
endinterface

// File: rtl/multi_port_memory.sv
// Byte-addressed memory, one write port and READ_PORTS registered read ports, self-clearing after reset.
// Define MULTI_PORT_MEMORY_READ_BYPASS_EN to forward same-cycle writes to colliding reads.
module multi_port_memory #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned READ_PORTS    = 2
) (
    input  logic               clock_in,
    input  logic               reset_in,
    multi_port_memory_if.slave bus
);
    localparam int unsigned        WORD_AW    = ADDRESS_WIDTH - 2;
    localparam int unsigned        DEPTH      = 1 << WORD_AW;
    localparam logic [WORD_AW-1:0] LAST_INDEX = WORD_AW'(DEPTH - 1);
    localparam logic [1:0]         MODE_WORD  = 2'b00;
    localparam logic [1:0]         MODE_HALF  = 2'b10;
    localparam logic [1:0]         MODE_BYTE  = 2'b11;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t             state_q, state_d;
    logic [WORD_AW-1:0] sweep_q;
    logic               clear_en_c, service_c;
    logic [31:0]        mem [DEPTH];

    logic [1:0]         w_lane_c;
    logic [WORD_AW-1:0] w_index_c;
    logic               w_bad_c, w_ok_c, w_reject_c;
    logic [3:0]         w_be_c;
    logic [31:0]        w_lanes_c, w_merged_c;

    logic [ADDRESS_WIDTH-1:0] r_addr_c [READ_PORTS];
    logic [31:0]              r_word_c [READ_PORTS];
    logic [31:0]              r_data_c [READ_PORTS];
    logic                     r_err_c  [READ_PORTS];

    // Returns {error, data} for one read lane selection.
    function automatic logic [32:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] mode, input logic sext);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [32:0] res;
        half_v = 16'(word >> {lane[1], 4'b0000});
        byte_v = 8'(word >> {lane, 3'b000});
        res    = {1'b1, 32'h0};
        case (mode)
            MODE_WORD: res = (lane == 2'b00) ? {1'b0, word} : {1'b1, 32'h0};
            MODE_HALF: res = lane[0] ? {1'b1, 32'h0} : {1'b0, {16{sext & half_v[15]}}, half_v};
            MODE_BYTE: res = {1'b0, {24{sext & byte_v[7]}}, byte_v};
            default:   res = {1'b1, 32'h0};
        endcase
        return res;
    endfunction

    always_ff @(posedge clock_in) begin
        if (reset_in) state_q <= ST_CLEAR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (sweep_q == LAST_INDEX) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
        endcase
    end

    always_comb begin
        clear_en_c = 1'b0;
        service_c  = 1'b0;
        case (state_q)
            ST_CLEAR: clear_en_c = 1'b1;
            ST_READY: service_c  = !reset_in;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in)        sweep_q <= '0;
        else if (clear_en_c) sweep_q <= sweep_q + WORD_AW'(1);
    end

    // Write decode: lane enables, replicated data and alignment check.
    always_comb begin
        w_lane_c  = bus.write_address_in[1:0];
        w_index_c = bus.write_address_in[ADDRESS_WIDTH-1:2];
        w_bad_c   = 1'b0;
        w_be_c    = 4'b0000;
        w_lanes_c = bus.write_data_in;
        case (bus.write_mode_in)
            MODE_WORD: begin
                w_bad_c = (w_lane_c != 2'b00);
                w_be_c  = 4'b1111;
            end
            MODE_HALF: begin
                w_bad_c   = w_lane_c[0];
                w_be_c    = w_lane_c[1] ? 4'b1100 : 4'b0011;
                w_lanes_c = {2{bus.write_data_in[15:0]}};
            end
            MODE_BYTE: begin
                w_be_c    = 4'b0001 << w_lane_c;
                w_lanes_c = {4{bus.write_data_in[7:0]}};
            end
            default: w_bad_c = 1'b1;
        endcase
        w_ok_c     = service_c && bus.write_in && !w_bad_c;
        w_reject_c = service_c && bus.write_in && w_bad_c;
        w_merged_c = mem[w_index_c];
        for (int b = 0; b < 4; b++) begin
            if (w_be_c[b]) w_merged_c[b*8 +: 8] = w_lanes_c[b*8 +: 8];
        end
    end

    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            r_addr_c[p] = bus.read_address_in[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            r_word_c[p] = mem[r_addr_c[p][ADDRESS_WIDTH-1:2]];
`ifdef MULTI_PORT_MEMORY_READ_BYPASS_EN
            if (w_ok_c && (r_addr_c[p][ADDRESS_WIDTH-1:2] == w_index_c)) r_word_c[p] = w_merged_c;
`endif
            {r_err_c[p], r_data_c[p]} = extract(r_word_c[p], r_addr_c[p][1:0],
                                                bus.read_mode_in[p*2 +: 2], bus.read_signed_in[p]);
        end
    end

    always_ff @(posedge clock_in) begin
        if (clear_en_c)  mem[sweep_q]   <= '0;
        else if (w_ok_c) mem[w_index_c] <= w_merged_c;
    end

    // Registered outputs; reads are forced quiet until the sweep is done.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            bus.read_data_out   <= '0;
            bus.read_error_out  <= '0;
            bus.write_error_out <= 1'b0;
            bus.ready_out       <= 1'b0;
        end else begin
            bus.write_error_out <= w_reject_c;
            bus.ready_out       <= (state_d == ST_READY);
            for (int p = 0; p < READ_PORTS; p++) begin
                bus.read_data_out[p*32 +: 32] <= service_c ? r_data_c[p] : 32'h0;
                bus.read_error_out[p]         <= service_c & r_err_c[p];
            end
        end
    end
endmodule

// File: tb/tb_multi_port_memory.sv
// Bench for multi_port_memory: byte-array reference model checked every cycle plus directed literals.
module tb_multi_port_memory;
    localparam int unsigned AW = 8;
    localparam int unsigned NP = 4;

    logic clock_in = 1'b0;
    logic reset_in = 1'b1;

    multi_port_memory_if #(.ADDRESS_WIDTH(AW), .READ_PORTS(NP)) bus ();
    multi_port_memory #(.ADDRESS_WIDTH(AW), .READ_PORTS(NP)) dut (
        .clock_in(clock_in),
        .reset_in(reset_in),
        .bus(bus)
    );

    always #5 clock_in = ~clock_in;

    logic [7:0]    mem_b [256];
    int            cnt    = 0;
    int            n_cmp  = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;
    logic [31:0]   exp_data [NP];
    logic [NP-1:0] exp_err;
    logic          exp_werr;
    logic          exp_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit bad_access(input logic [7:0] a, input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b00 && a[1:0] != 2'b00) || (m == 2'b10 && a[0]);
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [1:0] m, input logic [31:0] d);
        case (m)
            2'b00:   for (int i = 0; i < 4; i++) mem_b[8'(int'(a) + i)] = d[8*i +: 8];
            2'b10:   for (int i = 0; i < 2; i++) mem_b[8'(int'(a) + i)] = d[8*i +: 8];
            default: mem_b[a] = d[7:0];
        endcase
    endtask

    // Returns {error, data}.
    function automatic logic [32:0] model_read(input logic [7:0] a, input logic [1:0] m, input logic s);
        logic [7:0] b0, b1, b2, b3;
        if (bad_access(a, m)) return {1'b1, 32'h0};
        b0 = mem_b[a];
        b1 = mem_b[8'(int'(a) + 1)];
        b2 = mem_b[8'(int'(a) + 2)];
        b3 = mem_b[8'(int'(a) + 3)];
        case (m)
            2'b00:   return {1'b0, b3, b2, b1, b0};
            2'b10:   return {1'b0, {16{s & b1[7]}}, b1, b0};
            default: return {1'b0, {24{s & b0[7]}}, b0};
        endcase
    endfunction

    // Predict outputs for the coming edge from the current inputs, then advance one clock.
    task automatic cycle();
        int   k;
        bit   rej, wr_ok;
        logic [7:0] wa;
        if (reset_in) begin
            cnt = 0;
            foreach (mem_b[i]) mem_b[i] = 8'h00;
            foreach (exp_data[p]) exp_data[p] = 32'h0;
            exp_err = '0; exp_werr = 1'b0; exp_ready = 1'b0;
        end else begin
            k = cnt + 1;
            if (k <= 64) begin
                foreach (exp_data[p]) exp_data[p] = 32'h0;
                exp_err = '0; exp_werr = 1'b0; exp_ready = (k >= 64);
            end else begin
                wa    = bus.write_address_in;
                rej   = bad_access(wa, bus.write_mode_in);
                wr_ok = bus.write_in && !rej;
                exp_werr = bus.write_in && rej;
`ifdef MULTI_PORT_MEMORY_READ_BYPASS_EN
                if (wr_ok) model_write(wa, bus.write_mode_in, bus.write_data_in);
`endif
                for (int p = 0; p < NP; p++)
                    {exp_err[p], exp_data[p]} = model_read(bus.read_address_in[p*AW +: AW],
                                                           bus.read_mode_in[p*2 +: 2], bus.read_signed_in[p]);
`ifndef MULTI_PORT_MEMORY_READ_BYPASS_EN
                if (wr_ok) model_write(wa, bus.write_mode_in, bus.write_data_in);
`endif
                exp_ready = 1'b1;
            end
            cnt = (k > 1000) ? 1000 : k;
        end
        chk_en = 1'b1;
        @(posedge clock_in);
        #2;
    endtask

    task automatic idle();
        bus.write_in         = 1'b0;
        bus.write_mode_in    = 2'b00;
        bus.write_address_in = '0;
        bus.write_data_in    = '0;
        bus.read_address_in  = '0;
        bus.read_mode_in     = '0;
        bus.read_signed_in   = '0;
    endtask

    task automatic set_wr(input logic [1:0] m, input logic [7:0] a, input logic [31:0] d);
        bus.write_in         = 1'b1;
        bus.write_mode_in    = m;
        bus.write_address_in = a;
        bus.write_data_in    = d;
    endtask

    task automatic set_rd(input int p, input logic [1:0] m, input logic [7:0] a, input logic s);
        bus.read_address_in[p*AW +: AW] = a;
        bus.read_mode_in[p*2 +: 2]      = m;
        bus.read_signed_in[p]           = s;
    endtask

    function automatic logic [31:0] rd(input int p);
        return bus.read_data_out[p*32 +: 32];
    endfunction

    // Per-cycle comparison against the model.
    always @(posedge clock_in) begin
        if (chk_en) begin
            #1;
            check("ready_out", 32'(bus.ready_out), 32'(exp_ready));
            check("write_error_out", 32'(bus.write_error_out), 32'(exp_werr));
            for (int p = 0; p < NP; p++) begin
                check($sformatf("read_data_out[%0d]", p), rd(p), exp_data[p]);
                check($sformatf("read_error_out[%0d]", p), 32'(bus.read_error_out[p]), 32'(exp_err[p]));
            end
        end
    end

    task automatic sweep_and_check_ready(input string tag);
        for (int i = 1; i <= 64; i++) begin
            cycle();
            idle();
            if (i == 63) check({tag, " ready low before sweep end"}, 32'(bus.ready_out), 32'h0);
            if (i == 64) check({tag, " ready high after sweep"}, 32'(bus.ready_out), 32'h1);
        end
    endtask

    initial begin
        logic [7:0] bl_addr [4];
        logic [7:0] bl_data [4];
        bl_addr = '{8'h1c, 8'h1d, 8'h1e, 8'h1f};
        bl_data = '{8'hab, 8'hcd, 8'h00, 8'h1b};

        idle();
        reset_in = 1'b1;
        cycle();
        reset_in = 1'b0;
        check("reset ready_out", 32'(bus.ready_out), 32'h0);
        check("reset read_data_out[0]", rd(0), 32'h0);

        // Clear sweep with a write attempt that must be ignored.
        for (int i = 1; i <= 64; i++) begin
            if (i == 10) set_wr(2'b00, 8'h40, 32'hdeadbeef);
            cycle();
            idle();
            if (i == 10) check("clear write no error", 32'(bus.write_error_out), 32'h0);
            if (i == 63) check("ready low before sweep end", 32'(bus.ready_out), 32'h0);
            if (i == 64) check("ready high after sweep", 32'(bus.ready_out), 32'h1);
        end
        set_rd(0, 2'b00, 8'hfc, 1'b0);
        set_rd(1, 2'b00, 8'h40, 1'b0);
        cycle(); idle();
        check("cleared word 0xfc", rd(0), 32'h0);
        check("clear-time write ignored", rd(1), 32'h0);

        // Byte lanes.
        for (int i = 0; i < 4; i++) begin
            set_wr(2'b11, bl_addr[i], {24'h0, bl_data[i]});
            cycle();
        end
        idle();
        set_rd(0, 2'b00, 8'h1c, 1'b0);
        set_rd(1, 2'b11, 8'h1c, 1'b1);
        set_rd(2, 2'b11, 8'h1c, 1'b0);
        cycle(); idle();
        check("byte lanes word", rd(0), 32'h1b00cdab);
        check("byte signed", rd(1), 32'hffffffab);
        check("byte unsigned", rd(2), 32'h000000ab);

        // Half mode.
        set_wr(2'b10, 8'h18, 32'h0000abcd); cycle();
        set_wr(2'b10, 8'h1a, 32'h00000ff0); cycle();
        idle();
        set_rd(0, 2'b00, 8'h18, 1'b0);
        set_rd(1, 2'b10, 8'h18, 1'b1);
        cycle(); idle();
        check("half word", rd(0), 32'h0ff0abcd);
        check("half signed", rd(1), 32'hffffabcd);

        // Misalignment.
        set_wr(2'b10, 8'h19, 32'h1234abcd);
        cycle(); idle();
        check("misaligned write error", 32'(bus.write_error_out), 32'h1);
        set_rd(0, 2'b00, 8'h18, 1'b0);
        set_rd(1, 2'b00, 8'h1e, 1'b0);
        set_rd(2, 2'b11, 8'h1c, 1'b0);
        cycle(); idle();
        check("write error one cycle", 32'(bus.write_error_out), 32'h0);
        check("rejected write no change", rd(0), 32'h0ff0abcd);
        check("misaligned read data", rd(1), 32'h0);
        check("misaligned read error", 32'(bus.read_error_out), 32'b0010);
        check("other port unaffected", rd(2), 32'h000000ab);

        // Reserved mode on both ports.
        set_wr(2'b01, 8'h20, 32'hffffffff);
        set_rd(3, 2'b01, 8'h1c, 1'b0);
        cycle(); idle();
        check("reserved write error", 32'(bus.write_error_out), 32'h1);
        check("reserved read error", 32'(bus.read_error_out), 32'b1000);

        // Multi-port.
        set_wr(2'b00, 8'h00, 32'h00000001); cycle();
        set_wr(2'b00, 8'hfc, 32'hffff0f05); cycle();
        idle();
        set_rd(0, 2'b00, 8'h00, 1'b0);
        set_rd(1, 2'b00, 8'hfc, 1'b0);
        set_rd(2, 2'b00, 8'h1c, 1'b0);
        set_rd(3, 2'b00, 8'h00, 1'b0);
        cycle(); idle();
        check("multi port 0", rd(0), 32'h00000001);
        check("multi port 1", rd(1), 32'hffff0f05);
        check("multi port 2", rd(2), 32'h1b00cdab);
        check("multi port 3", rd(3), 32'h00000001);

        // Same-cycle read/write collision.
        set_wr(2'b00, 8'h20, 32'h11111111); cycle(); idle();
        set_wr(2'b11, 8'h21, 32'h00000022);
        set_rd(0, 2'b00, 8'h20, 1'b0);
        cycle(); idle();
`ifdef MULTI_PORT_MEMORY_READ_BYPASS_EN
        check("collision read", rd(0), 32'h11112211);
`else
        check("collision read", rd(0), 32'h11111111);
`endif
        set_rd(0, 2'b00, 8'h20, 1'b0);
        cycle(); idle();
        check("after collision", rd(0), 32'h11112211);

        // Reset mid-service, then mid-sweep; contents must be cleared again.
        reset_in = 1'b1; cycle(); reset_in = 1'b0;
        repeat (20) cycle();
        reset_in = 1'b1; cycle(); reset_in = 1'b0;
        sweep_and_check_ready("restart");
        set_rd(0, 2'b00, 8'h1c, 1'b0);
        set_rd(1, 2'b00, 8'h20, 1'b0);
        cycle(); idle();
        check("cleared after re-reset 0x1c", rd(0), 32'h0);
        check("cleared after re-reset 0x20", rd(1), 32'h0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
